ram_dual_port_pipelined: RTL and testbench

//  Vendor-neutral, inferred true dual-port RAM. Successor to the per-device altsyncram wrappers.
//  - Per-port byte enables and explicit read enables.
//  - Parametrised read latency, with a valid flag that travels with each read.
//  - Selectable mixed-port read-during-write mode.
//  - Defined same-address write collision handling.

---
 rtl/ram_pkg.sv | 27 ++
 rtl/ram_read_pipe.sv | 42 ++++
 rtl/ram_dual_port_pipelined.sv | 112 +++++++++++
 tb/tb_ram_dual_port_pipelined.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// Shared types, limits and byte-merge helper for the dual-port RAM.
// Imported by the RAM RTL and its bench model.
package ram_pkg;

    typedef enum logic {RDW_OLD, RDW_NEW} rdw_mode_e;

    localparam int MAX_RAM_LATENCY = 8;
    localparam int MAX_RAM_WIDTH   = 1024;
    localparam int MAX_RAM_BE      = MAX_RAM_WIDTH / 8;

    // Callers cast in and out of the widest supported word.
    function automatic logic [MAX_RAM_WIDTH-1:0] be_merge(
        input logic [MAX_RAM_WIDTH-1:0] old_w,
        input logic [MAX_RAM_WIDTH-1:0] new_w,
        input logic [MAX_RAM_BE-1:0]    be
    );
        logic [MAX_RAM_WIDTH-1:0] r;
        r = old_w;
        for (int i = 0; i < MAX_RAM_BE; i++) begin
            if (be[i]) begin
                r[8*i +: 8] = new_w[8*i +: 8];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/ram_read_pipe.sv
// Read data + valid shift register with enable and sync reset.
// q holds its last word while no valid result reaches the output.
module ram_read_pipe #(
    parameter int WIDTH   = 32,
    parameter int LATENCY = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);

    logic [WIDTH-1:0]   d [LATENCY];
    logic [LATENCY-1:0] v;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                d[i] <= '0;
            end
        end else if (en) begin
            v[0] <= in_valid;
            if (in_valid) begin
                d[0] <= in_data;
            end
            for (int i = 1; i < LATENCY; i++) begin
                v[i] <= v[i-1];
                if (v[i-1]) begin
                    d[i] <= d[i-1];
                end
            end
        end
    end

    assign out_valid = v[LATENCY-1];
    assign out_data  = d[LATENCY-1];

endmodule

// File: rtl/ram_dual_port_pipelined.sv
// Inferred true dual-port RAM with byte enables, pipelined reads,
// selectable mixed-port read-during-write and per-byte write collision merge.
module ram_dual_port_pipelined
    import ram_pkg::*;
#(
    parameter int        WIDTH     = 32,
    parameter int        DEPTH     = 256,
    parameter int        ADDR_W    = $clog2(DEPTH),
    parameter int        LATENCY   = 1,
    parameter int        BE_W      = WIDTH / 8,
    parameter rdw_mode_e RDW_MODE  = RDW_OLD,
    parameter            INIT_FILE = "UNUSED"
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clken,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic              rden_a,
    input  logic              wren_a,
    input  logic [WIDTH-1:0]  data_a,
    input  logic [BE_W-1:0]   byteena_a,
    output logic [WIDTH-1:0]  q_a,
    output logic              qvalid_a,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic              rden_b,
    input  logic              wren_b,
    input  logic [WIDTH-1:0]  data_b,
    input  logic [BE_W-1:0]   byteena_b,
    output logic [WIDTH-1:0]  q_b,
    output logic              qvalid_b
);

    if (WIDTH % 8 != 0) begin : g_bad_width
        $error("WIDTH must be a multiple of 8");
    end
    if (WIDTH > MAX_RAM_WIDTH || BE_W != WIDTH / 8) begin : g_bad_be
        $error("WIDTH/BE_W out of range");
    end
    if (LATENCY < 1 || LATENCY > MAX_RAM_LATENCY) begin : g_bad_lat
        $error("LATENCY must be 1..MAX_RAM_LATENCY");
    end

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];

    logic             in_a, in_b, wr_a, wr_b;
    logic [WIDTH-1:0] old_a, old_b, nxt_a, nxt_b, rd_a, rd_b;

    function automatic logic [WIDTH-1:0] merge(
        input logic [WIDTH-1:0] o,
        input logic [WIDTH-1:0] n,
        input logic [BE_W-1:0]  be
    );
        return WIDTH'(be_merge(MAX_RAM_WIDTH'(o), MAX_RAM_WIDTH'(n),
                               MAX_RAM_BE'(be)));
    endfunction

    // nxt_x is the word at addr_x after this edge: B applied, then A on top.
    always_comb begin
        in_a  = {1'b0, addr_a} < DEPTH_L;
        in_b  = {1'b0, addr_b} < DEPTH_L;
        wr_a  = clken & wren_a & in_a;
        wr_b  = clken & wren_b & in_b;
        old_a = in_a ? mem[addr_a] : '0;
        old_b = in_b ? mem[addr_b] : '0;

        nxt_a = old_a;
        if (wr_b && addr_b == addr_a) nxt_a = merge(nxt_a, data_b, byteena_b);
        if (wr_a) nxt_a = merge(nxt_a, data_a, byteena_a);

        nxt_b = old_b;
        if (wr_b) nxt_b = merge(nxt_b, data_b, byteena_b);
        if (wr_a && addr_a == addr_b) nxt_b = merge(nxt_b, data_a, byteena_a);

        if (RDW_MODE == RDW_NEW) begin
            rd_a = nxt_a;
            rd_b = nxt_b;
        end else begin
            rd_a = wr_a ? merge(old_a, data_a, byteena_a) : old_a;
            rd_b = wr_b ? merge(old_b, data_b, byteena_b) : old_b;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (wr_a) mem[addr_a] <= nxt_a;
            if (wr_b) mem[addr_b] <= nxt_b;
        end
    end

    ram_read_pipe #(.WIDTH(WIDTH), .LATENCY(LATENCY)) u_pipe_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (clken),
        .in_valid  (rden_a),
        .in_data   (rd_a),
        .out_valid (qvalid_a),
        .out_data  (q_a)
    );

    ram_read_pipe #(.WIDTH(WIDTH), .LATENCY(LATENCY)) u_pipe_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (clken),
        .in_valid  (rden_b),
        .in_data   (rd_b),
        .out_valid (qvalid_b),
        .out_data  (q_b)
    );

endmodule

// File: tb/tb_ram_dual_port_pipelined.sv
// Bench: two RAM configurations driven in parallel, checked every cycle
// against an array/queue reference model plus directed constant checks.
module tb_ram_dual_port_pipelined;
    import ram_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clken = 1'b0;
    logic [7:0]  addr_a = '0, addr_b = '0;
    logic        rden_a = 1'b0, rden_b = 1'b0;
    logic        wren_a = 1'b0, wren_b = 1'b0;
    logic [31:0] data_a = '0, data_b = '0;
    logic [3:0]  be_a = '0, be_b = '0;

    logic [31:0] q_a0, q_b0, q_a1, q_b1;
    logic        qv_a0, qv_b0, qv_a1, qv_b1;

    always #5 clk = ~clk;

    ram_dual_port_pipelined #(
        .DEPTH(200), .LATENCY(3), .RDW_MODE(RDW_OLD)
    ) u0 (
        .clk(clk), .rst_n(rst_n), .clken(clken),
        .addr_a(addr_a), .rden_a(rden_a), .wren_a(wren_a),
        .data_a(data_a), .byteena_a(be_a), .q_a(q_a0), .qvalid_a(qv_a0),
        .addr_b(addr_b), .rden_b(rden_b), .wren_b(wren_b),
        .data_b(data_b), .byteena_b(be_b), .q_b(q_b0), .qvalid_b(qv_b0)
    );

    ram_dual_port_pipelined #(
        .DEPTH(256), .LATENCY(2), .RDW_MODE(RDW_NEW)
    ) u1 (
        .clk(clk), .rst_n(rst_n), .clken(clken),
        .addr_a(addr_a), .rden_a(rden_a), .wren_a(wren_a),
        .data_a(data_a), .byteena_a(be_a), .q_a(q_a1), .qvalid_a(qv_a1),
        .addr_b(addr_b), .rden_b(rden_b), .wren_b(wren_b),
        .data_b(data_b), .byteena_b(be_b), .q_b(q_b1), .qvalid_b(qv_b1)
    );

    typedef struct {
        int          due;
        logic [31:0] d;
    } pend_t;

    pend_t       pq [2][2][$];
    logic [31:0] mm [2][256];
    logic [31:0] lq [2][2];
    logic        lv [2][2];
    int          dep [2];
    int          lat [2];
    bit          newm [2];
    int          ecnt = 0;
    int          n_tests = 0;
    int          n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] m32(input logic [31:0] o,
                                        input logic [31:0] n,
                                        input logic [3:0] be);
        return 32'(be_merge(MAX_RAM_WIDTH'(o), MAX_RAM_WIDTH'(n),
                            MAX_RAM_BE'(be)));
    endfunction

    // Memory word at addr once this edge's writes land (A wins shared bytes).
    function automatic logic [31:0] after(input int k, input logic [7:0] a);
        logic [31:0] w;
        w = mm[k][a];
        if (wren_b && addr_b < dep[k] && addr_b == a) w = m32(w, data_b, be_b);
        if (wren_a && addr_a < dep[k] && addr_a == a) w = m32(w, data_a, be_a);
        return w;
    endfunction

    task automatic model_edge();
        logic        ia, ib;
        logic [31:0] ra, rb, wa, wb;
        if (!rst_n) begin
            for (int k = 0; k < 2; k++)
                for (int p = 0; p < 2; p++) begin
                    pq[k][p].delete();
                    lq[k][p] = '0;
                    lv[k][p] = 1'b0;
                end
        end else if (clken) begin
            ecnt++;
            for (int k = 0; k < 2; k++) begin
                ia = addr_a < dep[k];
                ib = addr_b < dep[k];
                if (!ia) ra = '0;
                else if (newm[k]) ra = after(k, addr_a);
                else if (wren_a) ra = m32(mm[k][addr_a], data_a, be_a);
                else ra = mm[k][addr_a];
                if (!ib) rb = '0;
                else if (newm[k]) rb = after(k, addr_b);
                else if (wren_b) rb = m32(mm[k][addr_b], data_b, be_b);
                else rb = mm[k][addr_b];
                wa = after(k, addr_a);
                wb = after(k, addr_b);
                if (wren_a && ia) mm[k][addr_a] = wa;
                if (wren_b && ib) mm[k][addr_b] = wb;
                if (rden_a) pq[k][0].push_back('{ecnt + lat[k] - 1, ra});
                if (rden_b) pq[k][1].push_back('{ecnt + lat[k] - 1, rb});
                for (int p = 0; p < 2; p++) begin
                    if (pq[k][p].size() > 0 && pq[k][p][0].due == ecnt) begin
                        lv[k][p] = 1'b1;
                        lq[k][p] = pq[k][p][0].d;
                        void'(pq[k][p].pop_front());
                    end else begin
                        lv[k][p] = 1'b0;
                    end
                end
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check("q_a0", q_a0, lq[0][0]);
        check("q_b0", q_b0, lq[0][1]);
        check("q_a1", q_a1, lq[1][0]);
        check("q_b1", q_b1, lq[1][1]);
        check("qv_a0", 32'(qv_a0), 32'(lv[0][0]));
        check("qv_b0", 32'(qv_b0), 32'(lv[0][1]));
        check("qv_a1", 32'(qv_a1), 32'(lv[1][0]));
        check("qv_b1", 32'(qv_b1), 32'(lv[1][1]));
    endtask

    task automatic op(input bit ra, input bit wa, input logic [7:0] aa,
                      input logic [31:0] da, input logic [3:0] ba,
                      input bit rb, input bit wb, input logic [7:0] ab,
                      input logic [31:0] db, input logic [3:0] bb);
        rden_a = ra; wren_a = wa; addr_a = aa; data_a = da; be_a = ba;
        rden_b = rb; wren_b = wb; addr_b = ab; data_b = db; be_b = bb;
        cyc();
    endtask

    task automatic idle();
        op(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        dep[0] = 200; lat[0] = 3; newm[0] = 1'b0;
        dep[1] = 256; lat[1] = 2; newm[1] = 1'b1;
        for (int k = 0; k < 2; k++)
            for (int p = 0; p < 2; p++) begin
                lq[k][p] = '0;
                lv[k][p] = 1'b0;
            end

        rst_n = 1'b0;
        clken = 1'b0;
        idle();
        idle();
        check("rst_qa0", q_a0, 32'h0);
        check("rst_qvb1", 32'(qv_b1), 32'h0);
        rst_n = 1'b1;
        clken = 1'b1;
        for (int i = 0; i < 128; i++)
            op(0, 1, 8'(2*i), 0, 4'hF, 0, 1, 8'(2*i+1), 0, 4'hF);

        op(0, 1, 5, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0, 0);
        op(0, 0, 0, 0, 0, 1, 0, 5, 0, 0);
        idle();
        check("t1_qvb0_e2", 32'(qv_b0), 32'h0);
        check("t1_qb1", q_b1, 32'hDEADBEEF);
        idle();
        check("t1_qb0", q_b0, 32'hDEADBEEF);
        check("t1_qvb0_e3", 32'(qv_b0), 32'h1);

        op(0, 1, 9, 32'h11223344, 4'hF, 0, 0, 0, 0, 0);
        op(1, 1, 9, 32'hAABBCCDD, 4'b0101, 0, 0, 0, 0, 0);
        idle();
        check("t2_qa1", q_a1, 32'h11BB33DD);
        idle();
        check("t2_qa0", q_a0, 32'h11BB33DD);

        op(0, 1, 2, 32'hFFFFFFFF, 4'hF, 1, 0, 2, 0, 0);
        idle();
        check("t3_new", q_b1, 32'hFFFFFFFF);
        idle();
        check("t3_old", q_b0, 32'h0);
        check("t3_oldv", 32'(qv_b0), 32'h1);

        op(0, 1, 7, 32'h000000AA, 4'b0001, 0, 1, 7, 32'h0000BBCC, 4'b0011);
        op(1, 0, 7, 0, 0, 0, 0, 0, 0, 0);
        idle();
        check("t4_qa1", q_a1, 32'h0000BBAA);
        idle();
        check("t4_qa0", q_a0, 32'h0000BBAA);

        op(0, 0, 0, 0, 0, 1, 0, 5, 0, 0);
        clken = 1'b0;
        for (int i = 0; i < 3; i++) begin
            op(1, 1, 5, 32'h0BADF00D, 4'hF, 1, 1, 5, 32'h0BADF00D, 4'hF);
            check("t5_stall_qvb1", 32'(qv_b1), 32'h0);
        end
        clken = 1'b1;
        idle();
        check("t5_qb1", q_b1, 32'hDEADBEEF);
        check("t5_qvb1", 32'(qv_b1), 32'h1);
        idle();
        check("t5_qb0", q_b0, 32'hDEADBEEF);

        op(1, 0, 5, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        op(0, 1, 5, 32'h0BADF00D, 4'hF, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            idle();
            check("t5_rst_qva0", 32'(qv_a0), 32'h0);
            check("t5_rst_qva1", 32'(qv_a1), 32'h0);
        end
        op(1, 0, 5, 0, 0, 0, 0, 0, 0, 0);
        idle();
        idle();
        check("t5_keep", q_a0, 32'hDEADBEEF);

        op(0, 1, 250, 32'h12345678, 4'hF, 0, 0, 0, 0, 0);
        op(0, 0, 0, 0, 0, 1, 0, 250, 0, 0);
        idle();
        check("t6_qb1", q_b1, 32'h12345678);
        idle();
        check("t6_qb0", q_b0, 32'h0);
        check("t6_qvb0", 32'(qv_b0), 32'h1);

        for (int i = 0; i < 10000; i++) begin
            clken = ($urandom_range(0, 9) != 0);
            rst_n = ($urandom_range(0, 199) != 0);
            op(1'($urandom), 1'($urandom),
               ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 7)),
               $urandom, 4'($urandom),
               1'($urandom), 1'($urandom),
               ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 7)),
               $urandom, 4'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
